icache_fill_ctrl: RTL and testbench

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

---
 rtl/icache_fill_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache fill controller.
// Holds tag/valid metadata for 64 direct-mapped lines of 16 bytes each.
// Answers fetch lookups combinationally while idle.
// On a miss it streams the 8 halfwords of the line from main memory into the
// external instruction data array, then commits the tag in one extra cycle.
module icache_fill_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        flush,
    output logic        stall,
    output logic        hit,
    output logic        busy,
    input  logic        mem_grant,
    output logic        mem_enable,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_in,
    output logic        da_write,
    output logic [5:0]  da_block,
    output logic [2:0]  da_word,
    output logic [15:0] da_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRTAG = 2'd2
    } state_t;

    localparam int NUM_LINES = 64;

    // Architectural state
    state_t      r_state;
    logic [63:0] r_valid;
    logic [5:0]  r_tag [0:NUM_LINES-1];
    logic [11:0] r_miss_block;
    logic [3:0]  r_req_cnt;
    logic [3:0]  r_rsp_cnt;
    logic        r_flush_pend;

    // Combinational decode
    state_t      w_state_next;
    logic [5:0]  w_fetch_tag;
    logic [5:0]  w_fetch_index;
    logic [5:0]  w_miss_index;
    logic [5:0]  w_miss_tag;
    logic        w_lookup_hit;
    logic        w_hit;
    logic        w_stall;
    logic        w_busy;
    logic        w_mem_en;
    logic        w_da_write;
    logic        w_latch_miss;
    logic        w_flush_all;
    logic        w_wr_tag;
    logic        w_wr_valid;
    logic        w_last_rsp;
    logic [63:0] w_valid_next;
    logic        w_unused;

    // The word offset and byte bit of the fetch address do not affect lookup.
    assign w_unused = ^fetch_addr[3:0];

    assign w_fetch_tag   = fetch_addr[15:10];
    assign w_fetch_index = fetch_addr[9:4];
    assign w_miss_index  = r_miss_block[5:0];
    assign w_miss_tag    = r_miss_block[11:6];

    // Tag compare against the line selected by the current fetch address.
    assign w_lookup_hit = fetch_req & r_valid[w_fetch_index]
                        & (r_tag[w_fetch_index] == w_fetch_tag);

    // The eighth response closes the fill; rsp_cnt never advances past 7.
    assign w_last_rsp = mem_data_valid & (r_rsp_cnt == 4'd7);

    // A flush arriving during the commit cycle must still keep the new line
    // invalid, so the live flush input is folded in with the pending flag.
    assign w_wr_valid = ~(r_flush_pend | flush);

    // Next-state and per-state output decode.
    always_comb begin
        w_state_next = r_state;
        w_hit        = 1'b0;
        w_stall      = 1'b0;
        w_busy       = 1'b0;
        w_mem_en     = 1'b0;
        w_da_write   = 1'b0;
        w_latch_miss = 1'b0;
        w_flush_all  = 1'b0;
        w_wr_tag     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_hit       = w_lookup_hit;
                w_stall     = fetch_req & ~w_lookup_hit;
                w_flush_all = flush | r_flush_pend;
                if (fetch_req && !w_lookup_hit) begin
                    w_latch_miss = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                w_stall    = 1'b1;
                w_busy     = 1'b1;
                w_mem_en   = ~r_req_cnt[3] & mem_grant;
                w_da_write = mem_data_valid;
                if (w_last_rsp) begin
                    w_state_next = ST_WRTAG;
                end
            end
            ST_WRTAG: begin
                w_stall      = 1'b1;
                w_busy       = 1'b1;
                w_wr_tag     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Per-line valid update: global invalidate wins, otherwise the committing
    // line takes its new valid value and every other line holds.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            assign w_valid_next[gi] =
                w_flush_all ? 1'b0 :
                (w_wr_tag && (w_miss_index == 6'(gi))) ? w_wr_valid :
                r_valid[gi];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Valid bits; cleared by reset so an abandoned fill never leaves a live line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Tag store; contents are meaningless while the matching valid bit is 0.
    always_ff @(posedge clk) begin
        if (w_wr_tag) begin
            r_tag[w_miss_index] <= w_miss_tag;
        end
    end

    // Miss block latch plus request and response counters for the active fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_block <= '0;
            r_req_cnt    <= '0;
            r_rsp_cnt    <= '0;
        end else if (w_latch_miss) begin
            r_miss_block <= fetch_addr[15:4];
            r_req_cnt    <= '0;
            r_rsp_cnt    <= '0;
        end else if (r_state == ST_FILL) begin
            if (w_mem_en) begin
                r_req_cnt <= r_req_cnt + 4'd1;
            end
            if (mem_data_valid && !w_last_rsp) begin
                r_rsp_cnt <= r_rsp_cnt + 4'd1;
            end
        end
    end

    // Flush requests seen mid-fill are remembered until the next idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_flush_pend <= 1'b0;
        end else if (flush) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    assign hit        = w_hit & ~rst;
    assign stall      = w_stall & ~rst;
    assign busy       = w_busy & ~rst;
    assign mem_enable = w_mem_en & ~rst;
    assign da_write   = w_da_write & ~rst;
    assign mem_addr   = {r_miss_block, r_req_cnt[2:0], 1'b0};
    assign da_block   = w_miss_index;
    assign da_word    = r_rsp_cnt[2:0];
    assign da_data    = mem_data_in;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios followed by a random phase,
// checked every cycle against a line-level cache model and a 4-cycle memory.
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        flush;
    logic        stall;
    logic        hit;
    logic        busy;
    logic        mem_grant;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        da_write;
    logic [5:0]  da_block;
    logic [2:0]  da_word;
    logic [15:0] da_data;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .flush         (flush),
        .stall         (stall),
        .hit           (hit),
        .busy          (busy),
        .mem_grant     (mem_grant),
        .mem_enable    (mem_enable),
        .mem_addr      (mem_addr),
        .mem_data_valid(mem_data_valid),
        .mem_data_in   (mem_data_in),
        .da_write      (da_write),
        .da_block      (da_block),
        .da_word       (da_word),
        .da_data       (da_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cache contents plus progress of the fill in flight.
    bit          m_valid [64];
    logic [5:0]  m_tag   [64];
    int          m_phase;          // 0 lookup, 1 streaming words, 2 tag commit
    logic [11:0] m_block;
    logic [3:0]  m_asked;          // words requested so far
    logic [3:0]  m_got;            // words received so far
    bit          m_pend;

    // Main memory: fixed 4-cycle latency, in-order responses.
    typedef struct {
        int          due;
        logic [15:0] addr;
    } rsp_t;
    rsp_t mq[$];
    int   cyc = 0;
    int   req_seen = 0;
    int   wr_seen = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'h9E37;
        return t ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_phase = 0;
        m_pend  = 1'b0;
        m_asked = '0;
        m_got   = '0;
        mq.delete();
    endtask

    // One clock cycle: present memory data, check DUT outputs, advance model.
    task automatic run_cycle();
        logic        e_hit, e_stall, e_busy, e_en, e_wr;
        logic [5:0]  idx;
        logic [5:0]  tg;
        logic [15:0] word_addr;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data_in    = mem_word(mq[0].addr);
        end else begin
            mem_data_valid = 1'b0;
            mem_data_in    = 16'($urandom);
        end
        #2;
        idx = fetch_addr[9:4];
        tg  = fetch_addr[15:10];
        e_hit = 0; e_stall = 0; e_busy = 0; e_en = 0; e_wr = 0;
        if (!rst) begin
            if (m_phase == 0) begin
                e_hit   = fetch_req && m_valid[idx] && (m_tag[idx] == tg);
                e_stall = fetch_req && !e_hit;
            end else begin
                e_stall = 1;
                e_busy  = 1;
                if (m_phase == 1) begin
                    e_en = (m_asked < 8) && mem_grant;
                    e_wr = mem_data_valid;
                end
            end
        end
        chk("hit", hit, e_hit);
        chk("stall", stall, e_stall);
        chk("busy", busy, e_busy);
        chk("mem_enable", mem_enable, e_en);
        chk("da_write", da_write, e_wr);
        if (e_en) chk("mem_addr", mem_addr, {m_block, m_asked[2:0], 1'b0});
        if (e_wr) begin
            word_addr = {m_block, m_got[2:0], 1'b0};
            chk("da_block", da_block, m_block[5:0]);
            chk("da_word", da_word, m_got[2:0]);
            chk("da_data", da_data, mem_word(word_addr));
        end
        if (rst) begin
            model_reset();
        end else begin
            if (mem_data_valid) void'(mq.pop_front());
            if (mem_enable) begin
                mq.push_back('{due: cyc + 4, addr: mem_addr});
                req_seen++;
            end
            if (da_write) wr_seen++;
            case (m_phase)
                0: begin
                    if (flush || m_pend) begin
                        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
                        m_pend = 1'b0;
                    end
                    if (e_stall) begin
                        m_block = fetch_addr[15:4];
                        m_asked = '0;
                        m_got   = '0;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (e_en) m_asked = m_asked + 4'd1;
                    if (mem_data_valid) begin
                        if (m_got == 4'd7) m_phase = 2;
                        else m_got = m_got + 4'd1;
                    end
                    if (flush) m_pend = 1'b1;
                end
                default: begin
                    m_tag[m_block[5:0]]   = m_block[11:6];
                    m_valid[m_block[5:0]] = !(m_pend || flush);
                    m_pend  = m_pend || flush;
                    m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int maxc, input string tag);
        int k;
        k = 0;
        while (m_phase != 0 && k < maxc) begin
            run_cycle();
            k++;
        end
        total++;
        assert (m_phase == 0)
        else begin
            bad++;
            $error("FAIL %s timeout observed_busy=%0d required_busy=0", tag, busy);
        end
    endtask

    initial begin
        int k;
        rst            = 1'b1;
        fetch_req      = 1'b1;
        fetch_addr     = 16'h0000;
        flush          = 1'b0;
        mem_grant      = 1'b1;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        for (int i = 0; i < 64; i++) m_tag[i] = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Outputs quiet under reset even with a pending fetch.
        repeat (3) run_cycle();

        // Cold miss at 0x0000, then the stalled fetch hits.
        rst = 1'b0;
        run_cycle();
        run_until_idle(60, "cold_fill");
        run_cycle();
        chk("cold_hit", hit, 1'b1);

        // Hit on another word of the same line.
        fetch_addr = 16'h0006;
        run_cycle();

        // Conflicting tag on index 0 evicts the first line.
        fetch_addr = 16'h0400;
        run_cycle();
        run_until_idle(60, "conflict_fill");
        run_cycle();
        fetch_addr = 16'h0000;
        run_cycle();
        run_until_idle(60, "conflict_refill");
        run_cycle();

        // Grant alternating during a fill: exactly 8 requests in order.
        fetch_addr = 16'h1230;
        req_seen   = 0;
        run_cycle();
        k = 0;
        while (m_phase != 0 && k < 80) begin
            mem_grant = (k % 2 == 0);
            run_cycle();
            k++;
        end
        mem_grant = 1'b1;
        chk("gap_req_count", 16'(req_seen), 16'd8);
        run_cycle();

        // Flush pulse in the third fill cycle.
        fetch_addr = 16'h2000;
        run_cycle();
        run_cycle();
        run_cycle();
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        run_until_idle(60, "flush_fill");
        run_cycle();
        chk("flush_refetch_hit", hit, 1'b0);
        run_until_idle(60, "flush_refill");
        run_cycle();
        fetch_addr = 16'h1230;
        run_cycle();
        chk("flush_other_line_hit", hit, 1'b0);
        run_until_idle(60, "flush_other_refill");

        // Reset after four responses abandons the fill.
        fetch_addr = 16'h3450;
        run_cycle();
        k = 0;
        while (m_got < 4 && k < 60) begin
            run_cycle();
            k++;
        end
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_enable", mem_enable, 1'b0);
        chk("rst_da_write", da_write, 1'b0);
        model_reset();
        run_cycle();
        rst      = 1'b0;
        req_seen = 0;
        wr_seen  = 0;
        run_cycle();
        run_until_idle(60, "rst_refill");
        chk("rst_refill_req", 16'(req_seen), 16'd8);
        chk("rst_refill_wr", 16'(wr_seen), 16'd8);
        run_cycle();
        chk("rst_refill_hit", hit, 1'b1);

        // Random traffic over a small address pool to mix hits, misses, flushes.
        for (int n = 0; n < 500; n++) begin
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = {4'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          4'h0, 2'($urandom_range(0, 3)), 4'($urandom)};
            mem_grant  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            run_cycle();
        end
        flush     = 1'b0;
        mem_grant = 1'b1;
        run_until_idle(60, "random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
